// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory slave model with
// programmable grant and response latency over a word array.
module mem_responder #(
   parameter int          MEM_WORDS      = 1024,
   parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
   parameter int          GNT_LATENCY    = 2,
   parameter int          RVALID_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int          AW   = $clog2(MEM_WORDS);
   localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
   localparam bit          G0   = (GNT_LATENCY == 0);
   localparam logic [3:0]  GL1  = 4'(GNT_LATENCY - 1);
   localparam logic [3:0]  RL1  = 4'(RVALID_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_WAIT,
      RESP_WAIT,
      RESPOND
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] a_q;
   logic [31:0] d_q;
   logic        w_q;
   logic [3:0]  b_q;
   logic [31:0] rd_q;
   logic        er_q;

   logic [31:0] mem [MEM_WORDS];

   logic          sample;
   logic          commit;
   logic [31:0]   c_addr;
   logic          c_we;
   logic [3:0]    c_be;
   logic [31:0]   c_wd;
   logic [31:0]   off;
   logic          in_rng;
   logic [AW-1:0] idx;
   logic [31:0]   c_rd;

   // Commit decode: with zero grant latency the live inputs commit directly.
   always_comb begin
      sample = req_i && (state == IDLE || state == RESPOND);
      commit = 1'b0;
      if (!reset) begin
         if (G0)
            commit = sample;
         else
            commit = (state == GRANT_WAIT) && (cnt == GL1);
      end
      c_addr = G0 ? addr_i  : a_q;
      c_we   = G0 ? we_i    : w_q;
      c_be   = G0 ? be_i    : b_q;
      c_wd   = G0 ? wdata_i : d_q;
      off    = c_addr - BASE_ADDR;
      in_rng = (c_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
      idx    = off[AW+1:2];
      c_rd   = mem[idx];
   end

   // Byte-lane write into storage at the commit edge; never reset.
   always_ff @(posedge clk) begin
      if (commit && c_we && in_rng) begin
         for (int n = 0; n < 4; n++)
            if (c_be[n])
               mem[idx][8*n +: 8] <= c_wd[8*n +: 8];
      end
   end

   // Transaction FSM with registered grant/response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         a_q      <= '0;
         d_q      <= '0;
         w_q      <= 1'b0;
         b_q      <= '0;
         rd_q     <= '0;
         er_q     <= 1'b0;
         gnt_o    <= 1'b0;
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
      end else begin
         gnt_o    <= 1'b0;
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
         if (commit) begin
            gnt_o <= 1'b1;
            state <= RESP_WAIT;
            cnt   <= '0;
            rd_q  <= (!c_we && in_rng) ? c_rd : 32'h0;
            er_q  <= !in_rng;
         end else begin
            unique case (state)
               IDLE, RESPOND: begin
                  if (sample) begin
                     a_q   <= addr_i;
                     w_q   <= we_i;
                     b_q   <= be_i;
                     d_q   <= wdata_i;
                     cnt   <= '0;
                     state <= GRANT_WAIT;
                  end else begin
                     state <= IDLE;
                  end
               end
               GRANT_WAIT: begin
                  cnt <= cnt + 4'd1;
               end
               RESP_WAIT: begin
                  if (cnt == RL1) begin
                     state    <= RESPOND;
                     rvalid_o <= 1'b1;
                     rdata_o  <= rd_q;
                     err_o    <= er_q;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized transactions against a
// transaction-level memory model with cycle-exact timing checks.
module tb_mem_responder;

   localparam int          MW   = 1024;
   localparam logic [31:0] BASE = 32'h0010_0000;
   localparam int          G    = 2;
   localparam int          R    = 1;
   localparam int          P    = G + R + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_i;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mdl [int];
   int          pool [$];

   always #5 clk = ~clk;

   mem_responder dut (
      .clk      (clk),
      .reset    (reset),
      .req_i    (req_i),
      .addr_i   (addr_i),
      .we_i     (we_i),
      .be_i     (be_i),
      .wdata_i  (wdata_i),
      .gnt_o    (gnt_o),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o)
   );

   // Single comparison point for every check.
   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
      return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(4 * MW));
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   // Expected response payload, then apply the write to the model.
   task automatic model_txn(input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d,
                            output logic [31:0] erd, output logic eer);
      logic [31:0] v;
      erd = 32'h0;
      eer = !in_range(a);
      if (!eer) begin
         v = mdl.exists(word_of(a)) ? mdl[word_of(a)] : 32'h0;
         if (!w) begin
            erd = v;
         end else begin
            for (int n = 0; n < 4; n++)
               if (b[n]) v[8*n +: 8] = d[8*n +: 8];
            mdl[word_of(a)] = v;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_gnt"}, 32'(gnt_o), 32'h0);
      chk({tag, "_rvalid"}, 32'(rvalid_o), 32'h0);
      chk({tag, "_rdata"}, rdata_o, 32'h0);
      chk({tag, "_err"}, 32'(err_o), 32'h0);
   endtask

   // One transaction; inputs scrambled after the sample edge.
   task automatic run_txn(input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
      logic [31:0] erd;
      logic        eer;
      model_txn(a, w, b, d, erd, eer);
      req_i   = 1'b1;
      addr_i  = a;
      we_i    = w;
      be_i    = b;
      wdata_i = d;
      @(posedge clk);
      #1;
      req_i   = 1'b0;
      addr_i  = $urandom;
      we_i    = 1'($urandom);
      be_i    = 4'($urandom);
      wdata_i = $urandom;
      for (int m = 0; m <= G + R + 1; m++) begin
         chk("gnt", 32'(gnt_o), 32'(m == G));
         chk("rvalid", 32'(rvalid_o), 32'(m == G + R));
         chk("rdata", rdata_o, (m == G + R) ? erd : 32'h0);
         chk("err", 32'(err_o), (m == G + R) ? 32'(eer) : 32'h0);
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] pool_addr(input int i);
      return BASE + 32'(pool[i] * 4) + 32'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [31:0] a;
      logic [31:0] erd [3];
      logic        eer;
      logic [31:0] ra [3];
      int          sel;

      reset   = 1'b1;
      req_i   = 1'b1;
      addr_i  = BASE;
      we_i    = 1'b1;
      be_i    = 4'hF;
      wdata_i = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      req_i = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_idle("post_reset");

      run_txn(32'h0010_0008, 1'b1, 4'b1111, 32'hDEAD_BEEF);
      run_txn(32'h0010_0008, 1'b0, 4'b0000, 32'h0);
      run_txn(32'h0010_0008, 1'b1, 4'b0101, 32'h1122_3344);
      run_txn(32'h0010_0008, 1'b0, 4'b1010, 32'h0);
      run_txn(32'h0010_0000, 1'b1, 4'b1111, 32'hA5A5_0000);
      run_txn(32'h0010_1000, 1'b0, 4'b1111, 32'h0);
      run_txn(32'h0010_1000, 1'b1, 4'b1111, 32'h0BAD_0BAD);
      run_txn(32'h000F_FFFC, 1'b1, 4'b1111, 32'h0BAD_0BAD);
      run_txn(32'h0010_0000, 1'b0, 4'b1111, 32'h0);
      run_txn(32'h0010_0008, 1'b1, 4'b0000, 32'hFFFF_FFFF);
      run_txn(32'h0010_0008, 1'b0, 4'b0000, 32'h0);

      for (int i = 0; i < 16; i++) pool.push_back(i);
      pool.push_back(MW - 1);
      foreach (pool[i])
         run_txn(BASE + 32'(pool[i] * 4), 1'b1, 4'hF, $urandom);

      for (int t = 0; t < 200; t++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)
            a = BASE + 32'(4 * MW) + 32'($urandom_range(0, 64));
         else if (sel == 1)
            a = BASE - 32'($urandom_range(1, 64));
         else
            a = pool_addr(int'($urandom_range(0, pool.size() - 1)));
         run_txn(a, 1'($urandom), 4'($urandom), $urandom);
      end

      for (int n = 0; n < 3; n++) begin
         ra[n] = pool_addr(int'($urandom_range(0, pool.size() - 1)));
         model_txn(ra[n], 1'b0, 4'h0, 32'h0, erd[n], eer);
      end
      req_i  = 1'b1;
      we_i   = 1'b0;
      addr_i = ra[0];
      @(posedge clk);
      #1;
      for (int m = 0; m < 3 * P; m++) begin
         chk("b2b_gnt", 32'(gnt_o), 32'((m % P) == G));
         chk("b2b_rvalid", 32'(rvalid_o), 32'((m % P) == G + R));
         chk("b2b_rdata", rdata_o, ((m % P) == G + R) ? erd[m / P] : 32'h0);
         if ((m + 1) % P == 0 && (m + 1) / P < 3)
            addr_i = ra[(m + 1) / P];
         if (m == 3 * P - 1)
            req_i = 1'b0;
         else if ((m % P) != P - 1)
            addr_i = $urandom;
         @(posedge clk);
         #1;
      end
      check_idle("b2b_tail");

      req_i   = 1'b1;
      addr_i  = 32'h0010_0008;
      we_i    = 1'b1;
      be_i    = 4'hF;
      wdata_i = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      req_i = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int m = 0; m < 4; m++) begin
         check_idle("abort");
         @(posedge clk);
         #1;
      end
      run_txn(32'h0010_0008, 1'b0, 4'hF, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words of backing storage (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0010_0000, byte address of word 0.
REQ-003 SHALL have parameter GNT_LATENCY, default 2, extra cycles between request sample and grant (range 0-15).
REQ-004 SHALL have parameter RVALID_LATENCY, default 1, cycles from grant to response (range 1-15).
REQ-005 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports req_i in 1 request; addr_i in 32 byte address; we_i in 1 write enable; be_i in 4 byte enables; wdata_i in 32 write data.
REQ-008 SHALL have ports gnt_o out 1 grant pulse; rvalid_o out 1 response pulse; rdata_o out 32 read data; err_o out 1 response error.

Function
REQ-009 SHALL implement states IDLE, GRANT_WAIT, RESP_WAIT, RESPOND; at most one transaction outstanding.
REQ-010 In IDLE or RESPOND, req_i high at edge k SHALL latch addr_i, we_i, be_i, wdata_i and enter GRANT_WAIT; otherwise go/stay IDLE.
REQ-011 gnt_o SHALL be registered, high exactly one cycle: the cycle following edge k+GNT_LATENCY; low at all other times.
REQ-012 Memory access SHALL commit at edge k+GNT_LATENCY using the values latched at edge k; req_i/addr_i changes after edge k SHALL be ignored.
REQ-013 Address in range iff BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS; word index = (addr-BASE_ADDR)[log2(MEM_WORDS)+1:2]; addr[1:0] ignored.
REQ-014 In-range write: byte lane n SHALL be written iff be[n]=1; be=4'b0000 writes nothing but still completes normally.
REQ-015 In-range read: word value at commit edge SHALL be returned; be ignored for reads.
REQ-016 Out-of-range access: storage SHALL NOT be modified; response carries err_o=1, rdata_o=0.
REQ-017 After grant, state RESP_WAIT SHALL count RVALID_LATENCY-1 cycles; rvalid_o high exactly one cycle: the cycle following edge k+GNT_LATENCY+RVALID_LATENCY (state RESPOND).
REQ-018 rvalid_o SHALL pulse for writes as well as reads; write response rdata_o=0.
REQ-019 rdata_o and err_o SHALL be 0 whenever rvalid_o=0.
REQ-020 req_i in GRANT_WAIT or RESP_WAIT SHALL have no effect; it is sampled again only at the edge ending RESPOND (back-to-back) or in IDLE.
REQ-021 Read following write to same word SHALL return the newly written bytes merged with old unwritten bytes.
REQ-022 Latency counters SHALL be 4 bits and SHALL NOT wrap within a transaction.

Reset
REQ-023 reset high at an edge SHALL force IDLE, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, counters 0, latched request cleared.
REQ-024 Reset before commit edge SHALL abort the transaction with no storage write; writes already committed SHALL persist.
REQ-025 Storage contents SHALL NOT be cleared by reset.
REQ-026 req_i high during reset SHALL be ignored; first sample is the first edge with reset low.

Verification
REQ-027 Defaults; write addr 0x0010_0008, be 4'b1111, wdata 0xDEADBEEF, req at edge 0 -> gnt in cycle after edge 2, rvalid (err 0, rdata 0) after edge 3.
REQ-028 Then read 0x0010_0008 -> rvalid with rdata 0xDEADBEEF, err 0.
REQ-029 Write be 4'b0101 wdata 0x11223344 to same word, then read -> rdata 0xDE22BE44.
REQ-030 Read 0x0010_1000 (one past end, MEM_WORDS=1024) -> rvalid with err 1, rdata 0; storage unchanged.
REQ-031 req held high continuously for 3 reads -> responses spaced GNT_LATENCY+RVALID_LATENCY+1 cycles, no extra gnt pulses.
REQ-032 Write request, reset asserted at edge 1 (before commit) -> no gnt, no rvalid, subsequent read returns prior word value.
